// File: rtl/sync_fifo_if.sv
// Handshake bundle between a FIFO producer/consumer (master) and the FIFO (slave).
interface sync_fifo_if #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 3
);

  logic [DSIZE-1:0] wr_data;
  logic             wr_inc;
  logic             rd_inc;
  logic [DSIZE-1:0] rd_data;
  logic             wr_full;
  logic             rd_empty;

  modport master (
    output wr_data,
    output wr_inc,
    output rd_inc,
    input  rd_data,
    input  wr_full,
    input  rd_empty
  );

  modport slave (
    input  wr_data,
    input  wr_inc,
    input  rd_inc,
    output rd_data,
    output wr_full,
    output rd_empty
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO, 2**ASIZE x DSIZE, wrap-bit pointers.
module sync_fifo #(
  parameter int unsigned DSIZE = 8,
  parameter int unsigned ASIZE = 3
) (
  input logic       clk,
  input logic       rst,
  sync_fifo_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam int unsigned PW    = ASIZE + 1;

  logic [DSIZE-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;

  // Occupancy flags from the registered pointers; wrap bit separates full from empty.
  always_comb begin
    empty = (wptr == rptr);
    full  = (wptr[ASIZE] != rptr[ASIZE]) &&
            (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
    wr_en = bus.wr_inc && !full;
    rd_en = bus.rd_inc && !empty;
  end

  // Pointer advance and storage write; reset clears every entry so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wptr[ASIZE-1:0]] <= bus.wr_data;
        wptr                 <= wptr + PW'(1);
      end
      if (rd_en) begin
        rptr <= rptr + PW'(1);
      end
    end
  end

  // Head word falls through with no read latency.
  assign bus.rd_data  = mem[rptr[ASIZE-1:0]];
  assign bus.wr_full  = full;
  assign bus.rd_empty = empty;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: vector table, queue scoreboard, corner sequences.
module tb_sync_fifo;

  localparam int unsigned DSIZE = 8;
  localparam int unsigned ASIZE = 3;
  localparam int unsigned DEPTH = 1 << ASIZE;

  logic clk = 1'b0;
  logic rst;

  sync_fifo_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

  sync_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [DSIZE-1:0] sb [$];

  typedef struct {
    logic             wr;
    logic [DSIZE-1:0] data;
    logic             rd;
    logic             exp_empty;
    logic             exp_full;
    logic             chk_data;
    logic [DSIZE-1:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Compare flags and head word against the scoreboard contents.
  task automatic check_state(input string tag);
    check({tag, "_empty"}, 32'(bus.rd_empty), 32'(sb.size() == 0));
    check({tag, "_full"}, 32'(bus.wr_full), 32'(sb.size() == int'(DEPTH)));
    check({tag, "_excl"}, 32'(bus.rd_empty & bus.wr_full), 32'd0);
    if (sb.size() != 0) check({tag, "_data"}, 32'(bus.rd_data), 32'(sb[0]));
  endtask

  // One clock of stimulus; scoreboard updated from the pre-edge occupancy.
  task automatic cycle(input logic w, input logic [DSIZE-1:0] d, input logic r, input string tag);
    bit wa;
    bit ra;
    wa = w && (sb.size() < int'(DEPTH));
    ra = r && (sb.size() != 0);
    if (ra) check({tag, "_pop"}, 32'(bus.rd_data), 32'(sb[0]));
    bus.wr_inc  = w;
    bus.wr_data = d;
    bus.rd_inc  = r;
    @(posedge clk);
    #1;
    bus.wr_inc = 1'b0;
    bus.rd_inc = 1'b0;
    if (ra) void'(sb.pop_front());
    if (wa) sb.push_back(d);
    check_state(tag);
  endtask

  // Asynchronous reset pulse away from the clock edge, with requests held during reset.
  task automatic rst_pulse();
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_empty", 32'(bus.rd_empty), 32'd1);
    check("rst_async_full", 32'(bus.wr_full), 32'd0);
    check("rst_async_data", 32'(bus.rd_data), 32'h00);
    bus.wr_inc  = 1'b1;
    bus.wr_data = 8'h55;
    bus.rd_inc  = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hold_empty", 32'(bus.rd_empty), 32'd1);
    check("rst_hold_data", 32'(bus.rd_data), 32'h00);
    bus.wr_inc = 1'b0;
    bus.rd_inc = 1'b0;
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[1] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[5] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    rst         = 1'b1;
    bus.wr_inc  = 1'b0;
    bus.rd_inc  = 1'b0;
    bus.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_empty", 32'(bus.rd_empty), 32'd1);
    check("reset_full", 32'(bus.wr_full), 32'd0);
    check("reset_data", 32'(bus.rd_data), 32'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_empty", 32'(bus.rd_empty), 32'd1);
    check("idle_data", 32'(bus.rd_data), 32'h00);

    // Short write/read/empty-read sequence from the vector table.
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].wr, vecs[i].data, vecs[i].rd, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_tbl_empty", i), 32'(bus.rd_empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d_tbl_full", i), 32'(bus.wr_full), 32'(vecs[i].exp_full));
      if (vecs[i].chk_data) check($sformatf("vec%0d_tbl_data", i), 32'(bus.rd_data), 32'(vecs[i].exp_data));
    end

    // Fill to full, overflow write dropped, drain in order.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, "fill");
    check("fill_full", 32'(bus.wr_full), 32'd1);
    cycle(1'b1, 8'hFF, 1'b0, "ovf");
    check("ovf_head", 32'(bus.rd_data), 32'h01);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain%0d_order", i), 32'(bus.rd_data), 32'(i));
      cycle(1'b0, 8'h00, 1'b1, "drain");
    end
    check("drain_empty", 32'(bus.rd_empty), 32'd1);

    // Simultaneous request while full: read wins, write dropped.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, "refill");
    cycle(1'b1, 8'hEE, 1'b1, "full_both");
    check("full_both_full", 32'(bus.wr_full), 32'd0);
    check("full_both_occ", 32'(sb.size()), 32'd7);
    check("full_both_head", 32'(bus.rd_data), 32'h02);
    cycle(1'b1, 8'h44, 1'b1, "mid_both");
    check("mid_both_head", 32'(bus.rd_data), 32'h03);
    repeat (7) cycle(1'b0, 8'h00, 1'b1, "drain2");
    check("drain2_empty", 32'(bus.rd_empty), 32'd1);

    // Simultaneous request while empty: write wins, read dropped.
    cycle(1'b1, 8'h9D, 1'b1, "empty_both");
    check("empty_both_data", 32'(bus.rd_data), 32'h9D);
    cycle(1'b0, 8'h00, 1'b1, "empty_both_rd");

    // Alternating random traffic with a mid-stream reset.
    for (int i = 0; i < 60; i++) begin
      cycle(1'b1, 8'($urandom), 1'b0, "alt_wr");
      if (i == 29) rst_pulse();
      cycle(1'b0, 8'h00, 1'b1, "alt_rd");
    end

    // Random mixed traffic to exercise deep occupancy across pointer wraps.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45), "mix");
    end
    while (sb.size() != 0) cycle(1'b0, 8'h00, 1'b1, "final");
    check("final_empty", 32'(bus.rd_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
